spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_clk_gen.sv | 40 ++++
 rtl/spi_master_ctrl.sv | 151 +++++++++++++++
 tb/tb_spi_master_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } spi_state_t;

    // All slaves deselected; bit k of the [0:3] bus is slave k.
    localparam logic [0:3] SS_NONE = 4'b1111;

    // Width of a down-counter that must hold n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Active-low one-hot select for the given slave.
    function automatic logic [0:3] ss_decode(input logic [1:0] id);
        logic [0:3] sel;
        sel     = SS_NONE;
        sel[id] = 1'b0;
        return sel;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period down-counter with rise/fall strobes.
// Held in reset (sclk low, counter reloaded) whenever en is low, so every
// enable window starts with a full low half-period.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W  = cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;

    assign tick = en && (cnt == '0);
    assign rise = tick && !sclk;
    assign fall = tick && sclk;

    // Half-period counter; sclk flips at the end of each half-period.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= RELOAD;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt  <= RELOAD;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master, MSB first, four active-low slave selects.
// Build option: define SPI_LOOPBACK_EN to add the loopback input, which
// samples mosi instead of miso on rising sclk.
//
// state | meaning
// IDLE  | waiting for start; selects released
// SETUP | select asserted, first bit on mosi, CLK_DIV cycles
// SHIFT | sclk running for 2*DATA_W toggles
// HOLD  | select still asserted, sclk low, CLK_DIV cycles
// DONE  | select released, done pulse, rx_data updated
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        slave_id,
    input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [0:3]        ss_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int               WAIT_W   = cnt_w(CLK_DIV);
    localparam logic [WAIT_W-1:0] WAIT_RLD = WAIT_W'(CLK_DIV - 1);
    localparam int               TGL_W    = $clog2(2 * DATA_W);
    localparam logic [TGL_W-1:0]  TGL_LAST = TGL_W'(2 * DATA_W - 1);

    spi_state_t        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TGL_W-1:0]  tgl_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [1:0]        sel;
    logic              framing;
    logic              shift_en;
    logic              rise, fall;
    logic              sample;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (shift_en),
        .sclk (sclk),
        .rise (rise),
        .fall (fall)
    );

`ifdef SPI_LOOPBACK_EN
    assign sample = loopback ? mosi : miso;
`else
    assign sample = miso;
`endif

    assign mosi = framing ? tx_sh[DATA_W-1] : 1'b0;
    assign ss_n = framing ? ss_decode(sel) : SS_NONE;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_nxt = state;
        framing   = 1'b0;
        shift_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = SETUP;
            SETUP: begin
                framing = 1'b1;
                busy    = 1'b1;
                if (wait_cnt == '0) state_nxt = SHIFT;
            end
            SHIFT: begin
                framing  = 1'b1;
                busy     = 1'b1;
                shift_en = 1'b1;
                // The final toggle is always a falling edge.
                if (fall && tgl_cnt == '0) state_nxt = HOLD;
            end
            HOLD: begin
                framing = 1'b1;
                busy    = 1'b1;
                if (wait_cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame capture, phase timers, shift registers and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= WAIT_RLD;
            tgl_cnt  <= TGL_LAST;
            tx_sh    <= '0;
            rx_sh    <= '0;
            sel      <= 2'd0;
            rx_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sh    <= tx_data;
                        sel      <= slave_id;
                        rx_sh    <= '0;
                        wait_cnt <= WAIT_RLD;
                    end
                end
                SETUP: begin
                    if (wait_cnt == '0) begin
                        wait_cnt <= WAIT_RLD;
                        tgl_cnt  <= TGL_LAST;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (rise) rx_sh <= {rx_sh[DATA_W-2:0], sample};
                    if (rise || fall) tgl_cnt <= tgl_cnt - 1'b1;
                    // Keep the last bit on mosi after the final falling edge.
                    if (fall && tgl_cnt != '0) tx_sh <= tx_sh << 1;
                end
                HOLD: begin
                    if (wait_cnt == '0) rx_data <= rx_sh;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl (default DATA_W=8, CLK_DIV=4).
module tb_spi_master_ctrl;

    localparam int DW    = 8;
    localparam int CD    = 4;
    localparam int FRAME = 1 + CD * (2 * DW + 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    slave_id = 2'd0;
    logic [DW-1:0] tx_data = '0;
    logic          miso = 1'b0;
`ifdef SPI_LOOPBACK_EN
    logic          loopback = 1'b0;
    bit            lb_req = 1'b0;
`endif
    logic          sclk, mosi, busy, done;
    logic [0:3]    ss_n;
    logic [DW-1:0] rx_data;

    spi_master_ctrl #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .slave_id (slave_id),
        .tx_data  (tx_data),
`ifdef SPI_LOOPBACK_EN
        .loopback (loopback),
`endif
        .miso     (miso),
        .sclk     (sclk),
        .mosi     (mosi),
        .ss_n     (ss_n),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [DW-1:0] rx;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    bit            act = 1'b0;
    int            act_t = 0;
    logic [1:0]    act_sid = 2'd0;
    logic [DW-1:0] act_tx = '0;
    logic [DW-1:0] act_resp = '0;
    int            next_free = 0;
    logic [DW-1:0] rx_hold = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    // Frame phase for offset d from the accepting cycle:
    // 0 outside, 1 setup, 2 shift, 3 hold, 4 done.
    function automatic int region(input int d);
        if (d < 1)                  return 0;
        if (d <= CD)                return 1;
        if (d <= CD * (2 * DW + 1)) return 2;
        if (d <= CD * (2 * DW + 2)) return 3;
        if (d == FRAME)             return 4;
        return 0;
    endfunction

    // Slave model: bit n of the response is presented until the n-th rising sclk.
    function automatic logic miso_for(input int k);
        int d, rises;
        if (!act) return 1'b0;
        d = k - act_t;
        if (d < CD + 1)                  rises = 0;
        else if (d <= CD * (2 * DW + 1)) rises = (((d - CD - 1) / CD) + 1) / 2;
        else                             rises = DW;
        return (rises < DW) ? act_resp[DW-1-rises] : 1'b0;
    endfunction

    task automatic drive(input bit s, input logic [1:0] sid, input logic [DW-1:0] tx,
                         input logic [DW-1:0] resp);
        logic [DW-1:0] exp_rx;
        @(negedge clk);
        start    = s;
        slave_id = sid;
        tx_data  = tx;
        if (s && !rst && cyc >= next_free) begin
            act       = 1'b1;
            act_t     = cyc;
            act_sid   = sid;
            act_tx    = tx;
            act_resp  = resp;
            next_free = cyc + FRAME + 1;
`ifdef SPI_LOOPBACK_EN
            loopback = lb_req;
            exp_rx   = lb_req ? tx : resp;
`else
            exp_rx   = resp;
`endif
            exp_q.push_back('{cyc + FRAME, exp_rx});
        end
        miso = miso_for(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'($urandom), DW'($urandom), DW'($urandom));
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst       = 1'b1;
            start     = 1'b0;
            miso      = 1'b0;
            act       = 1'b0;
            next_free = 0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: per-cycle interface model plus done/rx scoreboard.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("rst_ss_n", 32'(ss_n), 32'hF);
            chk("rst_sclk", 32'(sclk), 32'd0);
            chk("rst_mosi", 32'(mosi), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_rx_data", 32'(rx_data), 32'd0);
            rx_hold = '0;
            exp_q.delete();
        end else begin
            int         d, r, p;
            logic [0:3] e_ss;
            logic       e_sclk;
            exp_t       e;
            d = act ? (cyc - act_t) : -1;
            r = act ? region(d) : 0;
            p = 0;
            e_ss = 4'b1111;
            if (r >= 1 && r <= 3) e_ss[act_sid] = 1'b0;
            e_sclk = 1'b0;
            if (r == 2) begin
                p      = (d - CD - 1) / CD;
                e_sclk = p[0];
            end
            chk("ss_n", 32'(ss_n), 32'(e_ss));
            chk("busy", 32'(busy), 32'(r != 0));
            chk("sclk", 32'(sclk), 32'(e_sclk));
            if (r == 1) chk("mosi_setup", 32'(mosi), 32'(act_tx[DW-1]));
            if (r == 2) chk("mosi_shift", 32'(mosi), 32'(act_tx[DW-1-p/2]));
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.due));
                    chk("rx_data", 32'(rx_data), 32'(e.rx));
                    rx_hold = e.rx;
                end
            end else begin
                if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                    chk("done_timeout", 32'(done), 32'd1);
                    void'(exp_q.pop_front());
                end
                chk("rx_hold", 32'(rx_data), 32'(rx_hold));
            end
        end
    end

    initial begin
        do_reset(2);

        // Basic frame: 0xA5 to slave 2, slave answers 0x3C.
        drive(1'b1, 2'd2, 8'hA5, 8'h3C);
        idle(FRAME + 4);

        // start during an active 0x00 frame must be ignored.
        drive(1'b1, 2'd0, 8'h00, DW'($urandom));
        idle(19);
        drive(1'b1, 2'd1, 8'hFF, DW'($urandom));
        idle(FRAME);

        // Reset 30 cycles into a frame, then a fresh frame.
        drive(1'b1, 2'd3, DW'($urandom), DW'($urandom));
        idle(29);
        do_reset(1);
        idle(3);
        drive(1'b1, 2'd1, DW'($urandom), DW'($urandom));
        idle(FRAME + 3);

        // start held high: back-to-back frames to slave 0.
        repeat (3 * (FRAME + 1) + 2) drive(1'b1, 2'd0, DW'($urandom), DW'($urandom));
        idle(FRAME + 3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
`ifdef SPI_LOOPBACK_EN
            lb_req = 1'($urandom);
`endif
            if ($urandom_range(0, 999) == 0) do_reset(1);
            else drive(($urandom_range(0, 5) == 0), 2'($urandom), DW'($urandom), DW'($urandom));
        end
        idle(FRAME + 3);

`ifdef SPI_LOOPBACK_EN
        // Loopback with miso held low returns the transmitted word.
        lb_req = 1'b1;
        drive(1'b1, 2'd1, 8'h5A, 8'h00);
        lb_req = 1'b0;
        idle(FRAME + 3);
`endif

        chk("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
